// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one mem_system port between fetch (read-only) and data (read/write); define MEM_ARB_RR_EN for round-robin instead of fixed data priority
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT        = 255,
  parameter int MAX_DATA_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;
  logic [1:0]  state;
  logic        wr_q;
  logic [15:0] tcnt;
  logic        grant_i, grant_d, done, tout;
`ifdef MEM_ARB_RR_EN
  logic last_d;
  assign grant_i = state == IDLE && if_req && (!d_req || last_d);
  // remember who was granted last so a contested arbitration alternates
  always_ff @(posedge clk or posedge rst)
    if (rst) last_d <= 1'b1;
    else if (grant_i || grant_d) last_d <= grant_d;
`else
  localparam int BW = $clog2(MAX_DATA_BURST + 2);
  logic [BW-1:0] burst;
  assign grant_i = state == IDLE && if_req && (!d_req || burst >= BW'(MAX_DATA_BURST));
  // count data grants made while fetch is waiting; a fetch grant restarts the count
  always_ff @(posedge clk or posedge rst)
    if (rst) burst <= '0;
    else if (grant_i) burst <= '0;
    else if (grant_d) burst <= if_req ? burst + 1'b1 : '0;
`endif
  assign grant_d   = state == IDLE && d_req && !grant_i;
  assign done      = state != IDLE && mem_valid;
  assign tout      = state != IDLE && !mem_valid && TIMEOUT != 0 && tcnt + 16'd1 == 16'(TIMEOUT);
  assign busy      = state != IDLE;
  assign mem_en    = busy;
  assign mem_wr    = busy && wr_q;
  assign if_valid  = done && state == BUSY_I;
  assign if_err    = tout && state == BUSY_I;
  assign d_valid   = done && state == BUSY_D;
  assign d_err     = tout && state == BUSY_D;
  assign if_rdata  = if_valid ? mem_rdata : '0;
  assign d_rdata   = d_valid ? mem_rdata : '0;
  // latch the winner's request at grant, hold it until completion or timeout
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= IDLE;
      wr_q      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      tcnt      <= '0;
    end else if (grant_i) begin
      state     <= BUSY_I;
      wr_q      <= 1'b0;
      mem_addr  <= if_addr;
      mem_wdata <= '0;
      tcnt      <= '0;
    end else if (grant_d) begin
      state     <= BUSY_D;
      wr_q      <= d_wr;
      mem_addr  <= d_addr;
      mem_wdata <= d_wdata;
      tcnt      <= '0;
    end else if (done || tout) begin
      state     <= IDLE;
    end else if (state != IDLE) begin
      tcnt      <= tcnt + 16'd1;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed literal checks plus randomized traffic against a transaction-level model
module tb_mem_port_arbiter;
  localparam int TO = 8;
  localparam int MB = 4;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic        clk = 1'b0, rst = 1'b1;
  logic        if_req = 1'b0, d_req = 1'b0, d_wr = 1'b0, mem_valid = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
  logic        if_valid, if_err, d_valid, d_err, mem_en, mem_wr, busy;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  int          checks = 0, errors = 0;
  bit          i_evt = 1'b0, d_evt = 1'b0;
  bit          m_act, m_d, m_wr, m_last_d;
  logic [31:0] m_addr, m_wdata;
  int          m_age, m_streak;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO), .MAX_DATA_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_valid(d_valid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_valid(mem_valid), .mem_rdata(mem_rdata), .busy(busy)
  );

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic ne;
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst = 1'b1; if_req = 1'b0; d_req = 1'b0; d_wr = 1'b0; mem_valid = 1'b0;
    tick;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    i_evt = if_valid | if_err;
    d_evt = d_valid | d_err;
  end

  // model: one outstanding transaction record, advanced once per cycle
  always @(negedge clk) begin : cmp
    bit done, to, win_d, vi, vd;
    if (rst) begin
      chk("rst_outs", {busy, mem_en, mem_wr, if_valid, if_err, d_valid, d_err}, 7'd0);
      chk("rst_addr", {mem_addr, mem_wdata}, 64'd0);
      chk("rst_rdata", {if_rdata, d_rdata}, 64'd0);
      m_act = 0; m_d = 0; m_wr = 0; m_last_d = 1; m_addr = '0; m_wdata = '0; m_age = 0; m_streak = 0;
    end else begin
      done = m_act && mem_valid;
      to   = m_act && !mem_valid && TO != 0 && m_age + 1 == TO;
      vi   = done && !m_d;
      vd   = done && m_d;
      chk("m_busy", {busy, mem_en, mem_wr}, {m_act, m_act, m_act && m_d && m_wr});
      chk("m_addr", {mem_addr, mem_wdata}, {m_addr, m_wdata});
      chk("m_if", {if_valid, if_err}, {vi, to && !m_d});
      chk("m_d", {d_valid, d_err}, {vd, to && m_d});
      chk("m_rdata", {if_rdata, d_rdata}, {vi ? mem_rdata : 32'd0, vd ? mem_rdata : 32'd0});
      if (m_act) begin
        if (done || to) m_act = 0;
        else m_age++;
      end else if (if_req || d_req) begin
        win_d    = d_req && !(if_req && (RR ? m_last_d : m_streak >= MB));
        m_act    = 1;
        m_d      = win_d;
        m_wr     = win_d && d_wr;
        m_addr   = win_d ? d_addr : if_addr;
        m_wdata  = win_d ? d_wdata : 32'd0;
        m_age    = 0;
        m_last_d = win_d;
        m_streak = (win_d && if_req) ? m_streak + 1 : 0;
      end
    end
  end

  initial begin
    bit first_d, exp_d;
    // fetch read completing on the third busy cycle
    tick; tick;
    rst = 1'b0;
    ne;
    chk("reset_state", {busy, mem_en, mem_wr, if_valid, d_valid, mem_addr}, 37'd0);
    tick;
    if_req = 1'b1; if_addr = 32'h0600_2000;
    ne; chk("t1_idle", busy, 1'b0);
    tick; ne;
    chk("t1_b1", {mem_en, mem_wr, mem_addr}, {1'b1, 1'b0, 32'h0600_2000});
    tick; ne; chk("t1_b2", {mem_en, if_valid}, 2'b10);
    tick;
    mem_valid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    ne;
    chk("t1_valid", {mem_en, if_valid, d_valid, if_rdata}, {3'b110, 32'hDEAD_BEEF});
    tick;
    if_req = 1'b0; mem_valid = 1'b0;
    ne; chk("t1_after", {busy, if_valid}, 2'b00);
    // simultaneous requests
    tick; do_reset;
    if_req = 1'b1; if_addr = 32'h0600_3000;
    d_req = 1'b1; d_wr = 1'b1; d_addr = 32'h1000_0000; d_wdata = 32'h5A5A_5A5A;
    first_d = !RR;
    tick; ne;
    chk("t2_first", {mem_wr, mem_addr, mem_wdata},
        first_d ? {1'b1, 32'h1000_0000, 32'h5A5A_5A5A} : {1'b0, 32'h0600_3000, 32'h0});
    tick;
    mem_valid = 1'b1; mem_rdata = 32'h0000_1111;
    ne; chk("t2_v1", {d_valid, if_valid}, {first_d, !first_d});
    tick;
    mem_valid = 1'b0;
    if (first_d) d_req = 1'b0; else if_req = 1'b0;
    ne; chk("t2_idle", busy, 1'b0);
    tick; ne;
    chk("t2_second", {mem_wr, mem_addr},
        first_d ? {1'b0, 32'h0600_3000} : {1'b1, 32'h1000_0000});
    tick;
    mem_valid = 1'b1;
    ne; chk("t2_v2", {d_valid, if_valid}, {!first_d, first_d});
    tick;
    mem_valid = 1'b0; if_req = 1'b0; d_req = 1'b0;
    // back-to-back data with fetch waiting
    tick; do_reset;
    if_req = 1'b1; if_addr = 32'h0000_0040;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h2000_0000;
    for (int g = 0; g < 6; g++) begin
      exp_d = RR ? (g % 2 == 1) : (g != 4);
      tick;
      mem_valid = 1'b1;
      ne; chk($sformatf("t3_grant%0d", g), {d_valid, if_valid}, {exp_d, !exp_d});
      tick;
      mem_valid = 1'b0;
    end
    if_req = 1'b0; d_req = 1'b0;
    // timeout
    tick; do_reset;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h3000_0000;
    tick;
    for (int k = 1; k <= TO; k++) begin
      ne; chk($sformatf("t4_cyc%0d", k), {d_err, d_valid, mem_en}, {k == TO, 1'b0, 1'b1});
      tick;
    end
    d_req = 1'b0;
    ne; chk("t4_idle", {busy, d_err}, 2'b00);
    // reset in the middle of a fetch
    tick;
    if_req = 1'b1; if_addr = 32'h0600_4000;
    tick; tick;
    rst = 1'b1;
    ne; chk("t5_rst", {mem_en, busy, mem_addr}, 34'd0);
    tick;
    rst = 1'b0; if_req = 1'b0; mem_valid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    ne; chk("t5_after", {if_valid, busy, if_rdata}, 34'd0);
    tick;
    mem_valid = 1'b0;
    // fetch request dropped while busy
    if_req = 1'b1; if_addr = 32'h0600_5000;
    tick; tick;
    if_req = 1'b0;
    ne; chk("t6_held", mem_en, 1'b1);
    tick;
    mem_valid = 1'b1; mem_rdata = 32'h0000_1234;
    ne; chk("t6_valid", {if_valid, if_rdata}, {1'b1, 32'h0000_1234});
    tick;
    mem_valid = 1'b0;
    ne; chk("t6_idle", busy, 1'b0);
    tick;
    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom % 500) == 0;
      if (if_req && (i_evt || ($urandom % 40) == 0)) if_req = 1'b0;
      else if (!if_req && ($urandom % 3) == 0) begin
        if_req = 1'b1; if_addr = $urandom;
      end
      if (d_req && (d_evt || ($urandom % 40) == 0)) d_req = 1'b0;
      else if (!d_req && ($urandom % 2) == 0) begin
        d_req = 1'b1; d_wr = $urandom % 2; d_addr = $urandom; d_wdata = $urandom;
      end
      mem_valid = ($urandom % 4) == 0;
      mem_rdata = $urandom;
      tick;
    end
    rst = 1'b0; if_req = 1'b0; d_req = 1'b0; mem_valid = 1'b0;
    repeat (3) tick;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
